// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl: two-key push-button front end producing a latched 2-bit display mode.
// Each key runs through a 2-flop synchroniser, a debouncer and a press classifier
// (short press fires on release, long press fires after a hold time). Short presses
// toggle individual mode bits; any long press clears the mode.
module key_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_slow,
    input  logic       key_fast,
    output logic [1:0] key_state,
    output logic [1:0] press_pulse,
    output logic [1:0] long_pulse,
    output logic [1:0] mode
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } press_state_t;

    // ---- stage p0/p1: synchroniser (raw keys are active-low, released level is 1)
    logic [1:0] sync_p0;
    logic [1:0] sync_p1;

    // Two-flop synchroniser for both raw keys; resets to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 2'b11;
            sync_p1 <= 2'b11;
        end else begin
            sync_p0 <= {key_fast, key_slow};
            sync_p1 <= sync_p0;
        end
    end

    generate
        for (genvar g = 0; g < 2; g++) begin : g_chan
            // ---- debounce stage: accept a level only after DEBOUNCE_CYCLES stable cycles
            logic [DB_W-1:0]   db_cnt;
            logic              db_level;
            logic              pressed_lvl;
            logic              mismatch;
            logic              flip;
            logic              rise;
            logic              fall;

            // ---- classify stage: press FSM and hold counter
            press_state_t      state;
            logic [HOLD_W-1:0] hold_cnt;
            logic              press_q;
            logic              long_q;

            // Synchronised level converted to "1 = pressed".
            assign pressed_lvl = ~sync_p1[g];
            assign mismatch    = pressed_lvl ^ db_level;
            assign flip        = mismatch && (db_cnt == DB_MAX);
            // The FSM reacts on the same edge that key_state flips, so pulse timing is
            // referenced directly to the debounced edge.
            assign rise        = flip && pressed_lvl;
            assign fall        = flip && !pressed_lvl;

            // Debouncer: count consecutive mismatched cycles, flip the level at the limit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    db_cnt   <= '0;
                    db_level <= 1'b0;
                end else if (!mismatch) begin
                    db_cnt <= '0;
                end else if (flip) begin
                    db_level <= pressed_lvl;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end

            // Press FSM: short press fires on release, long press fires once at hold limit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                    press_q  <= 1'b0;
                    long_q   <= 1'b0;
                end else begin
                    press_q <= 1'b0;
                    long_q  <= 1'b0;
                    case (state)
                        IDLE: begin
                            if (rise) begin
                                state    <= PRESSED;
                                hold_cnt <= '0;
                            end
                        end
                        PRESSED: begin
                            if (fall) begin
                                state   <= IDLE;
                                press_q <= 1'b1;
                            end else if (hold_cnt == HOLD_MAX) begin
                                // Counter stays at its maximum from here on (saturates in HELD).
                                state  <= HELD;
                                long_q <= 1'b1;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                        HELD: begin
                            // Release after a long press is silent.
                            if (fall) begin
                                state <= IDLE;
                            end
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end

            assign key_state[g]   = db_level;
            assign press_pulse[g] = press_q;
            assign long_pulse[g]  = long_q;
        end
    endgenerate

    // ---- mode stage: latched mode register, lags the pulses by one cycle
    // Mode update: any long press clears, otherwise short presses toggle their bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= 2'b00;
        end else if (|long_pulse) begin
            mode <= 2'b00;
        end else begin
            mode <= mode ^ press_pulse;
        end
    end

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Bench for key_mode_ctrl with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
// Expected pulse events (kind, bits, cycle) are queued when a key is driven and
// compared when the DUT raises press_pulse or long_pulse.
module tb_key_mode_ctrl;

    localparam int DB = 4;
    localparam int LG = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_slow = 1'b1;
    logic       key_fast = 1'b1;
    logic [1:0] key_state;
    logic [1:0] press_pulse;
    logic [1:0] long_pulse;
    logic [1:0] mode;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        bit         is_long;
        logic [1:0] bits;
        int         at;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    key_mode_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_slow   (key_slow),
        .key_fast   (key_fast),
        .key_state  (key_state),
        .press_pulse(press_pulse),
        .long_pulse (long_pulse),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every pulse seen must match the head of the expected queue.
    always @(negedge clk) begin
        if (press_pulse !== 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_press_pulse got=%b cycle=%0d required=no pulse", press_pulse, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_long || mon_e.bits !== press_pulse || mon_e.at != cyc) begin
                    failures++;
                    $display("FAIL press_event got=press bits=%b cycle=%0d required long=%0d bits=%b cycle=%0d",
                             press_pulse, cyc, mon_e.is_long, mon_e.bits, mon_e.at);
                end
            end
        end
        if (long_pulse !== 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_long_pulse got=%b cycle=%0d required=no pulse", long_pulse, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (!mon_e.is_long || mon_e.bits !== long_pulse || mon_e.at != cyc) begin
                    failures++;
                    $display("FAIL long_event got=long bits=%b cycle=%0d required long=%0d bits=%b cycle=%0d",
                             long_pulse, cyc, mon_e.is_long, mon_e.bits, mon_e.at);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drive the masked keys low for 'low' cycles, queue the expected event, check rise timing.
    task automatic press(input logic [1:0] mask, input int low);
        int c0;
        @(posedge clk);
        #1;
        if (mask[0]) key_slow = 1'b0;
        if (mask[1]) key_fast = 1'b0;
        c0 = cyc;
        if (low > LG)
            exp_q.push_back('{1'b1, mask, c0 + DB + 2 + LG});
        else if (low >= DB)
            exp_q.push_back('{1'b0, mask, c0 + low + DB + 2});
        if (low >= DB + 2) begin
            repeat (DB + 1) @(posedge clk);
            @(negedge clk);
            checks++;
            if ((key_state & mask) !== 2'b00) begin
                failures++;
                $display("FAIL key_state_early got=%b required=00 under mask %b", key_state & mask, mask);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ((key_state & mask) !== mask) begin
                failures++;
                $display("FAIL key_state_rise got=%b required=%b", key_state & mask, mask);
            end
            repeat (low - DB - 2) @(posedge clk);
        end else begin
            repeat (low) @(posedge clk);
        end
        #1;
        key_slow = 1'b1;
        key_fast = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        key_slow = 1'b1;
        key_fast = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({key_state, press_pulse, long_pulse, mode} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=00", {key_state, press_pulse, long_pulse, mode});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({key_state, press_pulse, long_pulse, mode} !== 8'h00) begin
                failures++;
                $display("FAIL post_reset_idle cycle %0d got=%h required=00", i,
                         {key_state, press_pulse, long_pulse, mode});
            end
        end
    endtask

    task automatic test_debounce_reject;
        for (int r = 0; r < 5; r++) begin
            @(posedge clk);
            #1;
            key_slow = 1'b0;
            repeat (DB - 1) @(posedge clk);
            #1;
            key_slow = 1'b1;
            repeat (3) @(posedge clk);
            @(negedge clk);
            checks++;
            if (key_state !== 2'b00) begin
                failures++;
                $display("FAIL glitch_key_state rep %0d got=%b required=00", r, key_state);
            end
        end
        idle(10);
        @(negedge clk);
        checks++;
        if (mode !== 2'b00) begin
            failures++;
            $display("FAIL glitch_mode got=%b required=00", mode);
        end
    endtask

    task automatic test_short_press;
        press(2'b01, 8);
        idle(12);
        @(negedge clk);
        checks++;
        if (mode !== 2'b01) begin
            failures++;
            $display("FAIL short_mode_set got=%b required=01", mode);
        end
        press(2'b01, 8);
        idle(12);
        @(negedge clk);
        checks++;
        if (mode !== 2'b00) begin
            failures++;
            $display("FAIL short_mode_clear got=%b required=00", mode);
        end
    endtask

    task automatic test_long_press;
        int c0;
        press(2'b01, 8);
        idle(12);
        press(2'b10, 8);
        idle(12);
        @(negedge clk);
        checks++;
        if (mode !== 2'b11) begin
            failures++;
            $display("FAIL long_setup_mode got=%b required=11", mode);
        end
        @(posedge clk);
        #1;
        key_fast = 1'b0;
        c0 = cyc;
        exp_q.push_back('{1'b1, 2'b10, c0 + DB + 2 + LG});
        repeat (DB + 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (key_state[1] !== 1'b0) begin
            failures++;
            $display("FAIL long_key_state_early got=%b required=0", key_state[1]);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (key_state[1] !== 1'b1) begin
            failures++;
            $display("FAIL long_key_state_rise got=%b required=1", key_state[1]);
        end
        repeat (LG) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mode !== 2'b11) begin
            failures++;
            $display("FAIL long_mode_on_pulse got=%b required=11", mode);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mode !== 2'b00) begin
            failures++;
            $display("FAIL long_mode_after_pulse got=%b required=00", mode);
        end
        repeat (40 - (DB + 2 + LG + 1)) @(posedge clk);
        #1;
        key_fast = 1'b1;
        idle(15);
        @(negedge clk);
        checks++;
        if (mode !== 2'b00) begin
            failures++;
            $display("FAIL long_mode_after_release got=%b required=00", mode);
        end
    endtask

    task automatic test_simultaneous;
        press(2'b11, 8);
        idle(12);
        @(negedge clk);
        checks++;
        if (mode !== 2'b11) begin
            failures++;
            $display("FAIL simultaneous_mode got=%b required=11", mode);
        end
    endtask

    task automatic test_reset_mid_press;
        int rel;
        // Reset during a press, key released as reset ends: nothing may fire.
        @(posedge clk);
        #1;
        key_slow = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({key_state, press_pulse, long_pulse, mode} !== 8'h00) begin
            failures++;
            $display("FAIL async_reset_outputs got=%h required=00", {key_state, press_pulse, long_pulse, mode});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        key_slow = 1'b1;
        idle(20);
        @(negedge clk);
        checks++;
        if (mode !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_press_mode got=%b required=00", mode);
        end
        // Key held through reset must be re-debounced and give a normal press.
        @(posedge clk);
        #1;
        key_slow = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel = cyc;
        exp_q.push_back('{1'b0, 2'b01, rel + 8 + DB + 2});
        repeat (8) @(posedge clk);
        #1;
        key_slow = 1'b1;
        idle(12);
        @(negedge clk);
        checks++;
        if (mode !== 2'b01) begin
            failures++;
            $display("FAIL held_through_reset_mode got=%b required=01", mode);
        end
    endtask

    task automatic check_queue_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_events got=%0d pending required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset;
        check_queue_drained("reset");
        test_debounce_reject;
        check_queue_drained("debounce");
        test_short_press;
        check_queue_drained("short");
        test_long_press;
        check_queue_drained("long");
        test_simultaneous;
        check_queue_drained("simultaneous");
        test_reset_mid_press;
        check_queue_drained("reset_mid_press");
        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
